// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional trace ports (dbg_state, dbg_rnd, dbg_strobe) are enabled by AES_ROUND_TRACE_EN.
module aes128_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic [127:0] dbg_state,
  output logic [3:0]   dbg_rnd,
  output logic         dbg_strobe
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t       r_state;
  state_t       w_stateNext;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_rkNext;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gfMul(s, s);
      r = gfMul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] keyExpand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]) ^ rc, sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign w_sb     = subBytes(r_st);
  assign w_sr     = shiftRows(w_sb);
  assign w_mc     = mixColumns(w_sr);
  assign w_rkNext = keyExpand(r_rk, rcon(r_rnd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_stateNext = S_ROUND;
      S_ROUND: if (r_rnd == 4'd10) w_stateNext = S_DONE;
      S_DONE:  if (out_ready) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // The final round skips MixColumns; rnd holds at 10 until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= '0;
      r_rk  <= '0;
      r_rnd <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_st  <= pt ^ key;
          r_rk  <= key;
          r_rnd <= 4'd1;
        end
        S_ROUND: begin
          r_st  <= (r_rnd == 4'd10) ? (w_sr ^ w_rkNext) : (w_mc ^ w_rkNext);
          r_rk  <= w_rkNext;
          r_rnd <= (r_rnd == 4'd10) ? 4'd10 : r_rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ROUND);
  assign ct        = (r_state == S_DONE) ? r_st : '0;

`ifdef AES_ROUND_TRACE_EN
  logic r_strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_strobe <= 1'b0;
    else     r_strobe <= (r_state == S_ROUND);
  end

  assign dbg_state  = r_st;
  assign dbg_rnd    = r_rnd;
  assign dbg_strobe = r_strobe;
`endif

endmodule
